// File: rtl/half_rate_generator.sv
// Clock synthesiser: programmable high/low half-rates with glitch-free rate changes at period boundaries.
// Latency: clk_o and events registered, 1 cycle after gen_en_i start; no backpressure, all state frozen while clk_en is low.
module half_rate_generator #(
   parameter int COUNTER_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     async_rst,
   input  logic                     clk_en,
   input  logic                     gen_en_i,
   input  logic                     idle_level_i,
   input  logic [COUNTER_WIDTH-1:0] high_rate_i,
   input  logic [COUNTER_WIDTH-1:0] low_rate_i,
   input  logic                     rate_load_i,
   input  logic                     clear_state_i,
   output logic                     clk_o,
   output logic                     rise_event_o,
   output logic                     fall_event_o,
   output logic                     active_o,
   output logic [COUNTER_WIDTH-1:0] current_rate_o,
   output logic                     rate_error_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_LOW  = 2'd2;

   localparam logic [COUNTER_WIDTH-1:0] RATE_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]               r_state;
   logic                     r_clk;
   logic                     r_rise;
   logic                     r_fall;
   logic                     r_idle;
   logic                     r_err;
   logic                     r_pend_vld;
   logic [COUNTER_WIDTH-1:0] r_cnt;
   logic [COUNTER_WIDTH-1:0] r_high;
   logic [COUNTER_WIDTH-1:0] r_low;
   logic [COUNTER_WIDTH-1:0] r_pend_high;
   logic [COUNTER_WIDTH-1:0] r_pend_low;

   logic [1:0]               w_state_nxt;
   logic                     w_clk_nxt;
   logic [COUNTER_WIDTH-1:0] w_cnt_nxt;
   logic                     w_boundary;
   logic                     w_phase_end;
   logic [COUNTER_WIDTH-1:0] w_phase_rate;
   logic [COUNTER_WIDTH-1:0] w_ld_high;
   logic [COUNTER_WIDTH-1:0] w_ld_low;
   logic                     w_ld_zero;

   // Zero rates are clamped to one cycle and flagged.
   assign w_ld_high    = (high_rate_i == '0) ? RATE_ONE : high_rate_i;
   assign w_ld_low     = (low_rate_i == '0) ? RATE_ONE : low_rate_i;
   assign w_ld_zero    = (high_rate_i == '0) || (low_rate_i == '0);
   assign w_phase_rate = (r_state == ST_HIGH) ? r_high : r_low;
   assign w_phase_end  = (r_cnt == w_phase_rate);

   always_comb begin
      w_state_nxt = r_state;
      w_clk_nxt   = r_clk;
      w_cnt_nxt   = r_cnt;
      w_boundary  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (gen_en_i) begin
               w_state_nxt = idle_level_i ? ST_LOW : ST_HIGH;
               w_clk_nxt   = ~idle_level_i;
               w_cnt_nxt   = RATE_ONE;
               w_boundary  = 1'b1;
            end else begin
               w_clk_nxt = idle_level_i;
               w_cnt_nxt = '0;
            end
         end
         ST_HIGH, ST_LOW: begin
            if (!w_phase_end) begin
               w_cnt_nxt = r_cnt + RATE_ONE;
            end else if (gen_en_i) begin
               w_state_nxt = (r_state == ST_HIGH) ? ST_LOW : ST_HIGH;
               w_clk_nxt   = (r_state == ST_LOW);
               w_cnt_nxt   = RATE_ONE;
               // A period starts when we leave the idle level again.
               w_boundary  = (w_clk_nxt != r_idle);
            end else begin
               w_state_nxt = ST_IDLE;
               w_clk_nxt   = r_idle;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_clk_nxt   = r_idle;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         r_state     <= ST_IDLE;
         r_clk       <= 1'b0;
         r_rise      <= 1'b0;
         r_fall      <= 1'b0;
         r_idle      <= 1'b0;
         r_err       <= 1'b0;
         r_pend_vld  <= 1'b0;
         r_cnt       <= '0;
         r_high      <= RATE_ONE;
         r_low       <= RATE_ONE;
         r_pend_high <= RATE_ONE;
         r_pend_low  <= RATE_ONE;
      end else if (clk_en) begin
         r_state <= w_state_nxt;
         r_clk   <= w_clk_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rise  <= w_clk_nxt & ~r_clk;
         r_fall  <= ~w_clk_nxt & r_clk;
         if ((r_state == ST_IDLE) && gen_en_i) begin
            r_idle <= idle_level_i;
         end
         if (rate_load_i) begin
            if (w_ld_zero) begin
               r_err <= 1'b1;
            end
         end else if (clear_state_i) begin
            r_err <= 1'b0;
         end
         // A load coinciding with the boundary bypasses the pending registers.
         if (w_boundary) begin
            if (rate_load_i) begin
               r_high <= w_ld_high;
               r_low  <= w_ld_low;
            end else if (r_pend_vld) begin
               r_high <= r_pend_high;
               r_low  <= r_pend_low;
            end
            r_pend_vld <= 1'b0;
         end else if (rate_load_i) begin
            r_pend_high <= w_ld_high;
            r_pend_low  <= w_ld_low;
            r_pend_vld  <= 1'b1;
         end else if (clear_state_i) begin
            r_pend_vld <= 1'b0;
         end
      end
   end

   // Event registers hold while gated so a pulse is seen in exactly one enabled cycle.
   assign clk_o          = r_clk;
   assign rise_event_o   = r_rise & clk_en;
   assign fall_event_o   = r_fall & clk_en;
   assign active_o       = (r_state != ST_IDLE);
   assign current_rate_o = r_cnt;
   assign rate_error_o   = r_err;

endmodule

// File: tb/tb_half_rate_generator.sv
// Bench for half_rate_generator: directed scenarios plus random stimulus against a phase-countdown reference model.
module tb_half_rate_generator;

   logic        clk;
   logic        async_rst;
   logic        clk_en;
   logic        gen_en_i;
   logic        idle_level_i;
   logic [15:0] high_rate_i;
   logic [15:0] low_rate_i;
   logic        rate_load_i;
   logic        clear_state_i;
   logic        clk_o;
   logic        rise_event_o;
   logic        fall_event_o;
   logic        active_o;
   logic [15:0] current_rate_o;
   logic        rate_error_o;

   half_rate_generator #(.COUNTER_WIDTH(16)) dut (
      .clk            (clk),
      .async_rst      (async_rst),
      .clk_en         (clk_en),
      .gen_en_i       (gen_en_i),
      .idle_level_i   (idle_level_i),
      .high_rate_i    (high_rate_i),
      .low_rate_i     (low_rate_i),
      .rate_load_i    (rate_load_i),
      .clear_state_i  (clear_state_i),
      .clk_o          (clk_o),
      .rise_event_o   (rise_event_o),
      .fall_event_o   (fall_event_o),
      .active_o       (active_o),
      .current_rate_o (current_rate_o),
      .rate_error_o   (rate_error_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Inputs staged for the next cycle.
   logic        n_rst, n_en, n_gen, n_idle, n_ld, n_clr;
   logic [15:0] n_hi, n_lo;

   // Reference model: running flag, phase level, position in phase, rate sets.
   bit          m_run, m_phase, m_idle, m_clk, m_rise, m_fall, m_err, m_pv;
   logic [15:0] m_pos, m_rh, m_rl, m_ph, m_pl;

   function automatic void model_reset();
      m_run = 0; m_phase = 0; m_idle = 0; m_clk = 0; m_rise = 0; m_fall = 0;
      m_err = 0; m_pv = 0; m_pos = 0; m_rh = 1; m_rl = 1; m_ph = 1; m_pl = 1;
   endfunction

   function automatic void model_step();
      bit          nclk;
      bit          bnd;
      logic [15:0] len;
      bnd = 0;
      len = m_phase ? m_rh : m_rl;
      if (!m_run) begin
         if (gen_en_i) begin
            m_idle = idle_level_i; m_run = 1; m_phase = !idle_level_i;
            m_pos = 1; nclk = m_phase; bnd = 1;
         end else begin
            m_pos = 0; nclk = idle_level_i;
         end
      end else if (m_pos < len) begin
         m_pos = m_pos + 16'd1; nclk = m_clk;
      end else if (gen_en_i) begin
         m_phase = !m_phase; m_pos = 1; nclk = m_phase; bnd = (m_phase != m_idle);
      end else begin
         m_run = 0; m_pos = 0; nclk = m_idle;
      end
      if (rate_load_i) begin
         if (high_rate_i == 0 || low_rate_i == 0) m_err = 1;
      end else if (clear_state_i) m_err = 0;
      if (bnd) begin
         if (rate_load_i) begin
            m_rh = (high_rate_i == 0) ? 16'd1 : high_rate_i;
            m_rl = (low_rate_i == 0) ? 16'd1 : low_rate_i;
         end else if (m_pv) begin
            m_rh = m_ph; m_rl = m_pl;
         end
         m_pv = 0;
      end else if (rate_load_i) begin
         m_ph = (high_rate_i == 0) ? 16'd1 : high_rate_i;
         m_pl = (low_rate_i == 0) ? 16'd1 : low_rate_i;
         m_pv = 1;
      end else if (clear_state_i) m_pv = 0;
      m_rise = nclk && !m_clk;
      m_fall = !nclk && m_clk;
      m_clk  = nclk;
   endfunction

   task automatic chk(input string tag, input string what, input logic [15:0] got, input logic [15:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s %s cyc=%0d got=%0h exp=%0h", tag, what, cyc, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk(tag, "clk_o",   16'(clk_o),        16'(m_clk));
      chk(tag, "rise",    16'(rise_event_o), 16'(m_rise & clk_en));
      chk(tag, "fall",    16'(fall_event_o), 16'(m_fall & clk_en));
      chk(tag, "active",  16'(active_o),     16'(m_run));
      chk(tag, "counter", current_rate_o,    m_pos);
      chk(tag, "error",   16'(rate_error_o), 16'(m_err));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (async_rst) model_reset();
      else if (clk_en) model_step();
      #1;
      async_rst = n_rst; clk_en = n_en; gen_en_i = n_gen; idle_level_i = n_idle;
      rate_load_i = n_ld; clear_state_i = n_clr; high_rate_i = n_hi; low_rate_i = n_lo;
      if (async_rst) model_reset();
      @(negedge clk);
      cyc++;
      check_all(tag);
   endtask

   task automatic load(input logic [15:0] hi, input logic [15:0] lo, input string tag);
      n_ld = 1; n_hi = hi; n_lo = lo;
      tick(tag);
      n_ld = 0;
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   initial begin
      async_rst = 1; clk_en = 1; gen_en_i = 0; idle_level_i = 0;
      rate_load_i = 0; clear_state_i = 0; high_rate_i = 0; low_rate_i = 0;
      n_rst = 1; n_en = 1; n_gen = 0; n_idle = 0; n_ld = 0; n_clr = 0; n_hi = 0; n_lo = 0;
      model_reset();
      run(2, "reset");
      n_rst = 0;
      run(2, "post_reset");

      // 3/2 waveform from start, checked against period arithmetic too.
      load(16'd3, 16'd2, "t1_load");
      n_gen = 1;
      tick("t1_start");
      for (int k = 1; k <= 12; k++) begin
         tick("t1_run");
         chk("t1_wave", "clk_o", 16'(clk_o), 16'(((k - 1) % 5) < 3));
         chk("t1_wave", "rise",  16'(rise_event_o), 16'((k % 5) == 1));
      end

      // Reload 1/1 mid high phase; takes effect at next rise.
      load(16'd1, 16'd1, "t2_load");
      run(10, "t2_run");

      // Stop during a 4-cycle high phase.
      n_gen = 0;
      run(4, "t3_drain");
      load(16'd4, 16'd2, "t3_load");
      n_gen = 1;
      tick("t3_start");
      tick("t3_high1");
      n_gen = 0;
      run(6, "t3_stop");
      chk("t3_idle", "active", 16'(active_o), 16'd0);

      // Idle-high start, stop during HIGH.
      n_idle = 1;
      load(16'd2, 16'd2, "t4_load");
      n_gen = 1;
      run(3, "t4_low");
      tick("t4_high1");
      n_gen = 0;
      run(5, "t4_stop");
      chk("t4_idle", "clk_o", 16'(clk_o), 16'd1);

      // Zero low rate is clamped and flagged; clear drops the flag only.
      n_idle = 0;
      run(2, "t5_idle");
      load(16'd2, 16'd0, "t5_load");
      n_gen = 1;
      run(8, "t5_run");
      chk("t5_err", "error", 16'(rate_error_o), 16'd1);
      n_clr = 1;
      tick("t5_clear");
      n_clr = 0;
      run(6, "t5_after");

      // Gated cycles stretch a phase; then async reset mid-run.
      load(16'd3, 16'd1, "t6_load");
      run(5, "t6_run");
      n_en = 0;
      run(2, "t6_gated");
      n_en = 1;
      run(8, "t6_resume");
      #2 async_rst = 1;
      #1;
      chk("t6_arst", "clk_o",  16'(clk_o),    16'd0);
      chk("t6_arst", "active", 16'(active_o), 16'd0);
      model_reset();
      n_rst = 1;
      tick("t6_in_reset");
      n_rst = 0;
      run(8, "t6_after_reset");

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         n_en   = ($urandom % 8) != 0;
         n_gen  = ($urandom % 10) != 0;
         if (($urandom % 16) == 0) n_idle = $urandom % 2;
         n_ld   = ($urandom % 12) == 0;
         n_hi   = 16'($urandom_range(0, 4));
         n_lo   = 16'($urandom_range(0, 4));
         n_clr  = ($urandom % 20) == 0;
         tick("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/half_rate_generator.md
Name: half_rate_generator

Overview:
Synthesises a clock on clk_o with independently programmable high and low half-rates, counted in system-clock cycles. It is the transmit-side counterpart of the half-rate recovery and sense path: the rise/fall event pulses it emits use the same semantics that block consumes. Rate changes are glitch-free because they apply only at period boundaries. Disabling always completes the current phase before parking at a programmed idle level.

Parameters:
COUNTER_WIDTH, 16, width of the rate registers and phase counter (equal to clks_alot_p::COUNTER_WIDTH).

Ports:
clk  in  1  system clock
async_rst  in  1  asynchronous, active-high reset
clk_en  in  1  qualifies every state/counter update; when low, all state is frozen
gen_en_i  in  1  level; start/continue generation
idle_level_i  in  1  level of clk_o while idle; sampled when leaving IDLE
high_rate_i  in  COUNTER_WIDTH  requested high half-rate (cycles)
low_rate_i  in  COUNTER_WIDTH  requested low half-rate (cycles)
rate_load_i  in  1  pulse; captures high_rate_i/low_rate_i into pending registers
clear_state_i  in  1  pulse; clears rate_error_o and drops any pending load
clk_o  out  1  generated clock, registered
rise_event_o  out  1  1-cycle pulse in the cycle clk_o becomes 1
fall_event_o  out  1  1-cycle pulse in the cycle clk_o becomes 0
active_o  out  1  high while state is not IDLE
current_rate_o  out  COUNTER_WIDTH  phase counter value
rate_error_o  out  1  sticky; a zero rate was loaded

Behaviour:
- Reset (async, immediate): state=IDLE, clk_o=0, events=0, active_o=0, counter=0, active high/low rates=1, pending empty, rate_error_o=0, latched idle level=0.
- All updates require clk_en=1. Event pulses assert only in enabled cycles and are 0 in any cycle with clk_en=0.
- States: IDLE, HIGH, LOW.
- IDLE: clk_o <= idle_level_i; counter=0. When gen_en_i=1:
  - latch idle_level_i;
  - apply pending rates if any;
  - enter the phase opposite the idle level (HIGH if idle=0, LOW if idle=1) on the next cycle, with counter=1 and the matching event pulse. Start latency is 1 cycle.
- HIGH/LOW: counter increments each enabled cycle. At counter == active rate for the phase (end of phase):
  - if gen_en_i=1: switch to the other phase, counter=1, toggle clk_o, pulse the matching event;
  - if gen_en_i=0: clk_o <= latched idle level, state=IDLE, active_o=0; event pulses only if the level changes.
  - Every phase therefore runs its full length; there are no runt pulses.
- Period boundary = entry into the phase opposite the idle level (including start from IDLE). Pending rates become active only there. A rate_load_i in the same cycle as a boundary takes effect at that boundary (bypass).
- Zero rate on load: clamp that rate to 1 and set rate_error_o. Non-zero rates are used as-is; maximum is 2^COUNTER_WIDTH-1. The counter counts 1..rate and never wraps.
- A second rate_load_i before the boundary overwrites the pending values.
- clear_state_i: clears rate_error_o and pending. It does not affect generation. If asserted with rate_load_i in the same cycle, the load wins and the error is set if the loaded value is 0.
- gen_en_i toggling mid-phase has no effect until the end of the phase. Re-asserting gen_en_i before the phase end continues without interruption.
- Changes to idle_level_i while not IDLE are ignored.

Test Plan:
1. Reset; idle=0; load high=3, low=2; gen_en_i=1 at cycle 0 -> clk_o=1 cycles 1-3, 0 cycles 4-5, repeating; rise at cycles 1, 6, 11; fall at cycles 4, 9; active_o=1 from cycle 1.
2. Running 3/2; load high=1, low=1 during a high phase -> current 3/2 period completes; from the next rise clk_o toggles every cycle; no phase shorter than 1 or altered mid-period.
3. idle=0, high=4; drop gen_en_i in the 2nd high cycle -> clk_o stays 1 through the 4th high cycle, then 0 with fall pulse; state IDLE, active_o=0, no further rise.
4. idle=1, high=2, low=2, enable -> first phase is LOW with fall pulse; disable during HIGH -> HIGH completes, clk_o stays 1 (no event), IDLE.
5. Load low=0 -> low phase lasts 1 cycle, rate_error_o=1 and holds; clear_state_i -> rate_error_o=0, output unaffected.
6. high=3 run with clk_en low 2 cycles mid-phase -> high lasts 5 system cycles, no events in gated cycles. Assert async_rst mid-run -> clk_o=0 and active_o=0 immediately; after release, rates=1 and clk_o toggles every cycle when enabled.
